// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU transmit framer: streams payload bytes through an external CRC engine
// and a UART, then appends the CRC low byte followed by the high byte.
module modbus_rtu_tx_framer #(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             crc_clr,
  output logic             crc_start,
  output logic [7:0]       crc_byte,
  input  logic             crc_busy,
  input  logic [15:0]      crc_value,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE, CLR, READ, LOAD, CRC_KICK, CRC_GUARD, CRC_WAIT,
    TX_KICK, TX_GUARD, TX_WAIT, CRC_LO, CRC_HI, FIN
  } state_t;

  // Which byte the shared TX_KICK/TX_GUARD/TX_WAIT sequence is currently sending.
  typedef enum logic [1:0] {PH_DATA, PH_LO, PH_HI} phase_t;

  state_t           state, state_next;
  phase_t           phase, phase_next;
  logic [LEN_W-1:0] len, len_next;
  logic [LEN_W-1:0] rd_addr_next;
  logic [7:0]       crc_byte_next, tx_data_next;
  logic             start_prev;
  logic             start_edge;
  logic             last_byte;

  assign start_edge = frame_start & ~start_prev;
  assign last_byte  = (rd_addr == (len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_DATA;
      len        <= '0;
      rd_addr    <= '0;
      crc_byte   <= '0;
      tx_data    <= '0;
      crc_clr    <= 1'b0;
      crc_start  <= 1'b0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      len        <= len_next;
      rd_addr    <= rd_addr_next;
      crc_byte   <= crc_byte_next;
      tx_data    <= tx_data_next;
      // Strobes are high for exactly the one cycle spent in their state.
      crc_clr    <= (state_next == CLR);
      crc_start  <= (state_next == CRC_KICK);
      tx_start   <= (state_next == TX_KICK);
      done       <= (state_next == FIN);
      busy       <= !(state_next inside {IDLE, FIN});
      start_prev <= frame_start;
    end
  end

  always_comb begin
    state_next    = state;
    phase_next    = phase;
    len_next      = len;
    rd_addr_next  = rd_addr;
    crc_byte_next = crc_byte;
    tx_data_next  = tx_data;
    case (state)
      IDLE: begin
        if (start_edge && (frame_len != '0)) begin
          state_next   = CLR;
          len_next     = frame_len;
          rd_addr_next = '0;
          phase_next   = PH_DATA;
        end
      end
      CLR:       state_next = READ;
      READ:      state_next = LOAD;
      LOAD: begin
        crc_byte_next = rd_data;
        tx_data_next  = rd_data;
        state_next    = CRC_KICK;
      end
      CRC_KICK:  state_next = CRC_GUARD;
      CRC_GUARD: state_next = CRC_WAIT;
      CRC_WAIT: begin
        if (!crc_busy) state_next = TX_KICK;
      end
      TX_KICK:   state_next = TX_GUARD;
      TX_GUARD:  state_next = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          case (phase)
            PH_DATA: begin
              if (last_byte) begin
                state_next = CRC_LO;
              end else begin
                rd_addr_next = rd_addr + LEN_W'(1);
                state_next   = READ;
              end
            end
            PH_LO:   state_next = CRC_HI;
            default: state_next = FIN;
          endcase
        end
      end
      CRC_LO: begin
        tx_data_next = crc_value[7:0];
        phase_next   = PH_LO;
        state_next   = TX_KICK;
      end
      CRC_HI: begin
        tx_data_next = crc_value[15:8];
        phase_next   = PH_HI;
        state_next   = TX_KICK;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/modbus_rtu_tx_framer.md
MODBUS_RTU_TX_FRAMER -- requirements
Module: modbus_rtu_tx_framer

Interface
REQ-001 SHALL have parameter LEN_W, default 6, width of frame_len and rd_addr (max frame 2^LEN_W-1 payload bytes).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port frame_start  input  1  frame request; acted on at rising edge only (registered previous value).
REQ-005 SHALL have port frame_len  input  LEN_W  payload byte count; sampled at the accepted frame_start edge.
REQ-006 SHALL have port rd_addr  output  LEN_W  payload buffer read address.
REQ-007 SHALL have port rd_data  input  8  payload buffer data; valid exactly one clk after rd_addr changes.
REQ-008 SHALL have port crc_clr  output  1  one-cycle clear pulse to the CRC engine reset.
REQ-009 SHALL have port crc_start  output  1  one-cycle strobe to the CRC engine start.
REQ-010 SHALL have port crc_byte  output  8  byte presented to the CRC engine; held stable until crc_busy falls.
REQ-011 SHALL have port crc_busy  input  1  CRC engine busy; rises one clk after crc_start.
REQ-012 SHALL have port crc_value  input  16  CRC engine result; valid when crc_busy low.
REQ-013 SHALL have port tx_start  output  1  one-cycle strobe to the UART transmitter.
REQ-014 SHALL have port tx_data  output  8  byte to transmit; held stable until tx_busy falls.
REQ-015 SHALL have port tx_busy  input  1  UART busy; rises one clk after tx_start.
REQ-016 SHALL have port busy  output  1  high from accepted frame_start edge until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the last CRC byte finishes transmitting.

Function
REQ-018 SHALL implement states IDLE, CLR, READ, LOAD, CRC_KICK, CRC_GUARD, CRC_WAIT, TX_KICK, TX_GUARD, TX_WAIT, CRC_LO, CRC_HI, FIN.
REQ-019 IDLE: on frame_start rising edge with frame_len!=0 SHALL latch frame_len, set rd_addr=0, busy=1, go CLR; with frame_len==0 SHALL ignore the edge (busy stays 0, no done).
REQ-020 CLR: SHALL pulse crc_clr for one clk, go READ.
REQ-021 READ: SHALL wait one clk for rd_data; LOAD SHALL capture rd_data into crc_byte and tx_data.
REQ-022 CRC_KICK SHALL pulse crc_start one clk; CRC_GUARD SHALL idle one clk (crc_start low, satisfying the engine's edge detect); CRC_WAIT SHALL hold until crc_busy==0.
REQ-023 TX_KICK SHALL pulse tx_start one clk; TX_GUARD SHALL idle one clk; TX_WAIT SHALL hold until tx_busy==0.
REQ-024 After TX_WAIT of a payload byte: if rd_addr==frame_len-1 SHALL go CRC_LO, else SHALL increment rd_addr and go READ.
REQ-025 CRC_LO SHALL load tx_data=crc_value[7:0] and run the TX_KICK/TX_GUARD/TX_WAIT sequence; then CRC_HI SHALL load tx_data=crc_value[15:8] likewise (low byte first, Modbus order).
REQ-026 FIN SHALL pulse done one clk, drop busy in the same clk, return to IDLE.
REQ-027 frame_start edges while busy SHALL be ignored; previous-value register SHALL update every clk regardless of state.
REQ-028 Per payload byte the CRC update SHALL complete before that byte's tx_start (serial, no overlap).
REQ-029 crc_start, tx_start, crc_clr, done SHALL never be high for two consecutive clks.

Reset
REQ-030 reset SHALL force state IDLE, busy=0, done=0, crc_start=0, tx_start=0, crc_clr=0, rd_addr=0, crc_byte=0, tx_data=0, previous frame_start=0; reset mid-frame SHALL abort with no done pulse.

Verification
REQ-031 Frame 01 03 00 00 00 01, frame_len=6, real CRC engine, UART model (tx_busy 10 clk) -> tx bytes 01 03 00 00 00 01 84 0A, one done pulse, busy low after.
REQ-032 frame_len=1, rd_data=0x01 -> tx bytes 01 7E 80, done once.
REQ-033 frame_start held high 200 clk / re-pulsed while busy -> exactly one frame sent.
REQ-034 frame_len=0 edge -> no crc_clr, no tx_start, busy stays 0, no done.
REQ-035 reset asserted during third payload byte's TX_WAIT -> next clk all outputs at reset values; following frame_start sends full correct frame.
REQ-036 Back-to-back frames (new edge one clk after done) -> second frame CRC starts from crc_clr, matches expected independently.
